// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer defaults and the clear-sequencer state encoding.
package vga_pkg;

    localparam int H_DISPLAY  = 640;
    localparam int H_L_BORDER = 48;
    localparam int H_R_BORDER = 16;
    localparam int H_RETRACE  = 96;
    localparam int H_MAX      = H_DISPLAY + H_L_BORDER + H_R_BORDER + H_RETRACE - 1;
    localparam int V_DISPLAY  = 480;
    localparam int V_T_BORDER = 10;
    localparam int V_B_BORDER = 33;
    localparam int V_RETRACE  = 2;
    localparam int V_MAX      = V_DISPLAY + V_T_BORDER + V_B_BORDER + V_RETRACE - 1;

    localparam int FB_W_DEF        = 160;
    localparam int FB_H_DEF        = 120;
    localparam int SCALE_SHIFT_DEF = 2;
    localparam int ADDR_W_DEF      = 15;
    localparam int DATA_W_DEF      = 3;
    localparam int FIFO_DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } clr_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Write-request and VRAM bus bundle; slave is the arbiter's view, master the surrounding logic.
interface vram_arbiter_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO holding pending {addr,data} writes; extra pointer bit separates full from empty.
module vram_wr_fifo
    import vga_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads own p_tick slots, FIFO writes and the clear sequencer use the rest.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int              FB_W        = FB_W_DEF,
    parameter int              FB_H        = FB_H_DEF,
    parameter int              SCALE_SHIFT = SCALE_SHIFT_DEF,
    parameter int              H_OFFSET    = H_L_BORDER,
    parameter int              ADDR_W      = ADDR_W_DEF,
    parameter int              DATA_W      = DATA_W_DEF,
    parameter int              FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [DATA_W-1:0] rgb,
    vram_arbiter_if.slave     bus
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(FB_W * FB_H - 1);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] px, input logic [9:0] py);
        logic [9:0] fx;
        logic [9:0] fy;
        fx = 10'(px - 10'(H_OFFSET)) >> SCALE_SHIFT;
        fy = py >> SCALE_SHIFT;
        return ADDR_W'(32'(fy) * 32'(FB_W) + 32'(fx));
    endfunction

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              disp_slot;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W-1:0] fifo_addr;
    logic [DATA_W-1:0] fifo_data;
    logic              en, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              pix_p0;
    logic              blank_p0;

    assign disp_slot    = p_tick && video_on;
    assign bus.wr_ready = !fifo_full && (state_q == IDLE);
    assign fifo_push    = bus.wr_valid && bus.wr_ready;
    assign fifo_pop     = !disp_slot && (state_q != CLEAR) && !fifo_empty;
    assign clr_busy     = (state_q != IDLE);

    vram_wr_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({bus.wr_addr, bus.wr_data}),
        .dout  ({fifo_addr, fifo_data}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        en      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        if (disp_slot) begin
            en   = 1'b1;
            addr = cell_addr(x, y);
        end else if (state_q == CLEAR) begin
            en    = 1'b1;
            we    = 1'b1;
            addr  = clr_cnt;
            wdata = CLEAR_VAL;
        end else if (!fifo_empty) begin
            en    = 1'b1;
            we    = 1'b1;
            addr  = fifo_addr;
            wdata = fifo_data;
        end
        case (state_q)
            IDLE:    if (clr_start) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = CLEAR;
            CLEAR:   if (!disp_slot && clr_cnt == LAST_CELL) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The bus is forced quiet the moment reset asserts, independent of the clock.
    assign bus.mem_en    = en && reset;
    assign bus.mem_we    = we && reset;
    assign bus.mem_addr  = reset ? addr  : '0;
    assign bus.mem_wdata = reset ? wdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DRAIN) clr_cnt <= '0;
            else if (state_q == CLEAR && !disp_slot) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // p0: remember the read slot; rdata is captured at the end of the following p_tick=0 clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_p0   <= 1'b0;
            blank_p0 <= 1'b1;
            rgb      <= '0;
        end else begin
            pix_p0   <= p_tick;
            blank_p0 <= !disp_slot;
            if (pix_p0) rgb <= blank_p0 ? '0 : bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: display addressing, pixel pipe, write FIFO, blanking drain and clear.
module tb_vram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       p_tick, video_on, clr_start;
    logic [9:0] x, y;
    logic       clr_busy;
    logic [2:0] rgb;

    int nvec = 0;
    int nmis = 0;

    vram_arbiter_if #(.ADDR_W(15), .DATA_W(3)) bus ();

    vram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .video_on  (video_on),
        .x         (x),
        .y         (y),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .rgb       (rgb),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic        acc, w_seen, busy_s, rdy_s;
    logic [17:0] w_val;
    logic [17:0] wq[$];
    int          disp_viol = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clk: drive slot type, sample mid-cycle, advance to 1 time unit past the next edge
    task automatic cyc(input bit pt, input bit von);
        p_tick = pt;
        video_on = von;
        #2;
        acc    = bus.wr_valid && bus.wr_ready;
        w_seen = bus.mem_en && bus.mem_we;
        w_val  = {bus.mem_addr, bus.mem_wdata};
        busy_s = clr_busy;
        rdy_s  = bus.wr_ready;
        if (w_seen) wq.push_back(w_val);
        if (w_seen && pt && von) disp_viol++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          idx, nw, bad, rdy_bad, last_c, drop_c;
        logic        hit;
        logic [17:0] pre[2];
        logic [2:0]  d3;

        reset = 1'b0; p_tick = 1'b1; video_on = 1'b1; clr_start = 1'b0;
        x = 10'd48; y = 10'd0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.mem_rdata = '0;
        #2;
        chk("rst_rgb", rgb, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;

        // idle display reads
        x = 10'd48; y = 10'd0; p_tick = 1'b1; video_on = 1'b1; #2;
        chk("disp0_en", bus.mem_en, 1);
        chk("disp0_we", bus.mem_we, 0);
        chk("disp0_addr", bus.mem_addr, 0);
        @(posedge clk); #1;
        p_tick = 1'b0; #2;
        chk("nodisp_en", bus.mem_en, 0);
        @(posedge clk); #1;
        x = 10'd52; y = 10'd4; p_tick = 1'b1; #2;
        chk("disp161_addr", bus.mem_addr, 161);
        @(posedge clk); #1;
        p_tick = 1'b0; bus.mem_rdata = 3'b101; #2;
        chk("rgb_before", rgb, 0);
        @(posedge clk); #1;
        chk("rgb_101", rgb, 3'b101);
        x = 10'd687; y = 10'd479; p_tick = 1'b1; bus.mem_rdata = 3'b000; #2;
        chk("rgb_hold", rgb, 3'b101);
        chk("disp_last_addr", bus.mem_addr, 19199);
        @(posedge clk); #1;
        p_tick = 1'b0; bus.mem_rdata = 3'b011;
        @(posedge clk); #1;
        chk("rgb_011", rgb, 3'b011);

        // border pixel: no read, blank colour
        x = 10'd0; y = 10'd10; p_tick = 1'b1; video_on = 1'b0; #2;
        chk("border_en", bus.mem_en, 0);
        @(posedge clk); #1;
        p_tick = 1'b0; bus.mem_rdata = 3'b111;
        @(posedge clk); #1;
        chk("border_rgb", rgb, 0);

        // write burst during active video
        x = 10'd100; y = 10'd100; wq.delete(); idx = 0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 15'(100 + idx); bus.wr_data = 3'(idx + 1);
            cyc(1'b1, 1'b1);
            if (acc) idx++;
        end
        chk("burst_fill", idx, 4);
        bus.wr_addr = 15'(100 + idx); bus.wr_data = 3'(idx + 1);
        cyc(1'b1, 1'b1);
        chk("full_ready", acc, 0);
        for (int c = 0; c < 20; c++) begin
            bus.wr_valid = (idx < 6);
            bus.wr_addr = 15'(100 + idx); bus.wr_data = 3'(idx + 1);
            cyc(c[0], 1'b1);
            if (acc) idx++;
        end
        bus.wr_valid = 1'b0;
        chk("burst_pushed", idx, 6);
        chk("burst_writes", wq.size(), 6);
        for (int i = 0; i < 6; i++) chk("burst_order", wq[i], {15'(100 + i), 3'(i + 1)});
        chk("disp_slot_writes", disp_viol, 0);

        // blanking drain: four writes in four consecutive clks
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            d3 = 3'(i + 3);
            bus.wr_valid = 1'b1; bus.wr_addr = 15'(200 + i); bus.wr_data = d3;
            cyc(1'b1, 1'b1);
            if (acc) idx++;
        end
        bus.wr_valid = 1'b0;
        chk("blank_fill", idx, 4);
        for (int i = 0; i < 5; i++) begin
            d3 = 3'(i + 3);
            cyc(i[0] ? 1'b0 : 1'b1, 1'b0);
            chk("blank_we", w_seen, (i < 4) ? 1 : 0);
            if (i < 4) chk("blank_data", w_val, {15'(200 + i), d3});
        end

        // clear with two queued writes
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 15'(300 + i); bus.wr_data = 3'(6 + i);
            cyc(1'b1, 1'b1);
        end
        bus.wr_valid = 1'b0;
        clr_start = 1'b1;
        cyc(1'b1, 1'b1);
        clr_start = 1'b0;
        chk("clr_busy_set", clr_busy, 1);
        nw = 0; bad = 0; rdy_bad = 0; last_c = -10; drop_c = -1;
        pre[0] = '0; pre[1] = '0;
        for (int c = 0; c < 25000; c++) begin
            cyc(c[0], 1'b0);
            if (w_seen) begin
                if (nw < 2) pre[nw] = w_val;
                else begin
                    if (w_val !== {15'(nw - 2), 3'b000}) bad++;
                    if (nw - 2 == 19199) last_c = c;
                end
                nw++;
            end
            if (busy_s && rdy_s) rdy_bad++;
            if (!busy_s) begin
                drop_c = c;
                break;
            end
        end
        chk("clr_pre0", pre[0], {15'd300, 3'd6});
        chk("clr_pre1", pre[1], {15'd301, 3'd7});
        chk("clr_total_writes", nw, 19202);
        chk("clr_bad_writes", bad, 0);
        chk("clr_ready_low", rdy_bad, 0);
        chk("clr_busy_drop", drop_c, last_c + 1);

        // reset in the middle of a clear
        clr_start = 1'b1;
        cyc(1'b0, 1'b0);
        clr_start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            p_tick = c[0]; video_on = 1'b0; #2;
            if (bus.mem_en && bus.mem_we && bus.mem_addr == 15'd5000) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; #1;
        chk("midclr_reached", hit, 1);
        chk("midclr_en", bus.mem_en, 0);
        chk("midclr_we", bus.mem_we, 0);
        chk("midclr_rgb", rgb, 0);
        chk("midclr_busy", clr_busy, 0);
        @(posedge clk); #1;
        reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; #2;
        chk("post_busy", clr_busy, 0);
        chk("post_ready", bus.wr_ready, 1);
        chk("post_idle_en", bus.mem_en, 0);
        @(posedge clk); #1;
        bus.wr_valid = 1'b1; bus.wr_addr = 15'd400; bus.wr_data = 3'd2;
        cyc(1'b1, 1'b1);
        bus.wr_valid = 1'b0;
        chk("post_push", acc, 1);
        cyc(1'b0, 1'b0);
        chk("post_write_we", w_seen, 1);
        chk("post_write", w_val, {15'd400, 3'd2});
        cyc(1'b0, 1'b0);
        chk("post_empty", w_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
